// File: rtl/mmio_host_bridge_pkg.sv
// Shared types and constants for the host-to-MMIO request bridge.
package mmio_host_bridge_pkg;

  // Bridge sequencing states.
  typedef enum logic [2:0] {
    IDLE,
    WR_ISSUE,
    RD_ISSUE,
    RD_WAIT,
    RSP
  } state_t;

  // Response status codes returned to the host.
  typedef enum logic [1:0] {
    ST_OK        = 2'd0,
    ST_UNALIGNED = 2'd1,
    ST_WINDOW    = 2'd2,
    ST_TIMEOUT   = 2'd3
  } status_t;

  // Upper address half that selects the MMIO register window.
  localparam logic [15:0] DEFAULT_WINDOW_HI = 16'hBEEF;

endpackage

// File: rtl/mmio_host_bridge.sv
// Converts single valid/ready host transactions into the MMIO block's
// one-cycle wr/rd strobes, waits for read data, and returns a status response.
module mmio_host_bridge
  import mmio_host_bridge_pkg::*;
#(
  parameter logic [15:0] WINDOW_HI      = DEFAULT_WINDOW_HI,
  parameter int          TIMEOUT_CYCLES = 16,
  parameter int          CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic        clk,
  input  logic        rst,
  // Host request channel
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  // Host response channel
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_write,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_status,
  // MMIO register block side
  output logic [31:0] mmio_addr,
  output logic [31:0] mmio_wdata,
  output logic        mmio_wr,
  output logic        mmio_rd,
  input  logic        mmio_rd_valid,
  input  logic [31:0] mmio_rdata
);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_mmio_addr;
  logic [31:0]      r_mmio_wdata;
  logic             r_rsp_write;
  logic [31:0]      r_rsp_rdata;
  status_t          r_rsp_status;

  state_t           w_next_state;
  logic             w_accept;
  logic             w_capture;
  logic             w_mmio_wr;
  logic             w_mmio_rd;
  logic             w_rsp_load;
  status_t          w_rsp_status;
  logic [31:0]      w_rsp_rdata;
  logic             w_timeout;

  assign req_ready = (r_state == IDLE) && !rst;
  assign w_accept  = req_valid && req_ready;
  assign w_timeout = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Next-state decode, strobe generation and response loading.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    w_next_state = r_state;
    w_capture    = 1'b0;
    w_mmio_wr    = 1'b0;
    w_mmio_rd    = 1'b0;
    w_rsp_load   = 1'b0;
    w_rsp_status = ST_OK;
    w_rsp_rdata  = '0;
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          // Alignment is checked before the window so a doubly-bad address
          // reports UNALIGNED; faulted requests never reach the bus.
          if (req_addr[1:0] != 2'b00) begin
            w_next_state = RSP;
            w_rsp_load   = 1'b1;
            w_rsp_status = ST_UNALIGNED;
          end else if (req_addr[31:16] != WINDOW_HI) begin
            w_next_state = RSP;
            w_rsp_load   = 1'b1;
            w_rsp_status = ST_WINDOW;
          end else begin
            w_capture    = 1'b1;
            w_next_state = req_write ? WR_ISSUE : RD_ISSUE;
          end
        end
      end
      WR_ISSUE: begin
        w_mmio_wr    = 1'b1;
        w_next_state = RSP;
        w_rsp_load   = 1'b1;
      end
      RD_ISSUE: begin
        w_mmio_rd    = 1'b1;
        w_next_state = RD_WAIT;
      end
      RD_WAIT: begin
        if (mmio_rd_valid) begin
          w_next_state = RSP;
          w_rsp_load   = 1'b1;
          w_rsp_rdata  = mmio_rdata;
        end else if (w_timeout) begin
          w_next_state = RSP;
          w_rsp_load   = 1'b1;
          w_rsp_status = ST_TIMEOUT;
        end
      end
      RSP: begin
        if (rsp_ready) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // State, captured request, timeout counter and held response registers.
  always_ff @(posedge clk) begin
    // NOTE: reset clears every register here, including the held response,
    // so a transaction in flight is dropped and never presented.
    if (rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_mmio_addr  <= '0;
      r_mmio_wdata <= '0;
      r_rsp_write  <= 1'b0;
      r_rsp_rdata  <= '0;
      r_rsp_status <= ST_OK;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling
      // pre-edge values, independent of statement order.
      r_state <= w_next_state;
      if (w_capture) begin
        r_mmio_addr <= req_addr;
        if (req_write) r_mmio_wdata <= req_wdata;
      end
      if (w_accept) r_rsp_write <= req_write;
      if (r_state == RD_ISSUE) begin
        r_cnt <= '0;
      end else if (r_state == RD_WAIT && !mmio_rd_valid) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_rsp_load) begin
        r_rsp_rdata  <= w_rsp_rdata;
        r_rsp_status <= w_rsp_status;
      end
    end
  end

  assign rsp_valid  = (r_state == RSP);
  assign rsp_write  = r_rsp_write;
  assign rsp_rdata  = r_rsp_rdata;
  assign rsp_status = r_rsp_status;
  assign mmio_addr  = r_mmio_addr;
  assign mmio_wdata = r_mmio_wdata;
  assign mmio_wr    = w_mmio_wr;
  assign mmio_rd    = w_mmio_rd;

endmodule

// File: tb/tb_mmio_host_bridge.sv
// Scoreboard bench for mmio_host_bridge with a small register block model
// downstream (0x0 RW, 0x4 RW, 0x8 ID=47, 0xC mirror of 0x0, others 0) and a
// stub mode whose read-valid never returns.
module tb_mmio_host_bridge;
  import mmio_host_bridge_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic        rsp_write;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_status;
  logic [31:0] mmio_addr;
  logic [31:0] mmio_wdata;
  logic        mmio_wr;
  logic        mmio_rd;
  logic        mmio_rd_valid;
  logic [31:0] mmio_rdata;

  always #5 clk = ~clk;

  mmio_host_bridge #(
    .WINDOW_HI     (16'hBEEF),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_write    (rsp_write),
    .rsp_rdata    (rsp_rdata),
    .rsp_status   (rsp_status),
    .mmio_addr    (mmio_addr),
    .mmio_wdata   (mmio_wdata),
    .mmio_wr      (mmio_wr),
    .mmio_rd      (mmio_rd),
    .mmio_rd_valid(mmio_rd_valid),
    .mmio_rdata   (mmio_rdata)
  );

  // Downstream register block model and timeout stub.
  logic        stub_mode = 1'b0;
  logic        stray = 1'b0;
  logic [31:0] reg0 = '0;
  logic [31:0] reg1 = '0;
  logic        blk_rd_valid = 1'b0;
  logic [31:0] blk_rdata = '0;
  int          wr_cnt = 0;
  int          rd_cnt = 0;
  int          cyc = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mmio_wr) wr_cnt <= wr_cnt + 1;
    if (mmio_rd) rd_cnt <= rd_cnt + 1;
    if (mmio_wr) begin
      case (mmio_addr[7:0])
        8'h00:   reg0 <= mmio_wdata;
        8'h04:   reg1 <= mmio_wdata;
        default: ;
      endcase
    end
    blk_rd_valid <= mmio_rd;
    if (mmio_rd) begin
      case (mmio_addr[7:0])
        8'h00:   blk_rdata <= reg0;
        8'h04:   blk_rdata <= reg1;
        8'h08:   blk_rdata <= 32'd47;
        8'h0C:   blk_rdata <= reg0;
        default: blk_rdata <= 32'd0;
      endcase
    end
  end

  assign mmio_rd_valid = stub_mode ? stray : blk_rd_valid;
  assign mmio_rdata    = stub_mode ? 32'hDEAD_BEEF : blk_rdata;

  // Scoreboard
  typedef struct {
    logic        write;
    logic [31:0] rdata;
    logic [1:0]  status;
    int          lat;   // negedges from accept edge to first rsp_valid
    int          acc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: pops the expected response on every response handshake.
  logic vis_prev = 1'b0;
  int   first_cyc = 0;
  always @(negedge clk) begin
    int   fc;
    exp_t e;
    fc = (rsp_valid && !vis_prev) ? cyc : first_cyc;
    first_cyc <= fc;
    vis_prev  <= rsp_valid;
    if (rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("rsp_write", {31'd0, rsp_write}, {31'd0, e.write});
        check("rsp_rdata", rsp_rdata, e.rdata);
        check("rsp_status", {30'd0, rsp_status}, {30'd0, e.status});
        check("rsp_latency", 32'(fc - e.acc), 32'(e.lat));
      end
    end
  end

  // Called at posedge+#1; returns at posedge+#1 after the accept edge.
  task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] rdata_e, input status_t st_e, input int lat_e);
    exp_t e;
    int   t;
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!req_ready && t < 50);
    if (!req_ready) begin
      check("req_accept_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    e.write  = wr;
    e.rdata  = rdata_e;
    e.status = st_e;
    e.lat    = lat_e;
    e.acc    = cyc;
    exp_q.push_back(e);
    req_valid = 1'b0;
    req_addr  = 32'hFFFF_FFFF;
    req_wdata = 32'hA5A5_A5A5;
  endtask

  task automatic wait_rsp();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      check("rsp_wait_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req_ready"}, {31'd0, req_ready}, 32'd0);
    check({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
    check({tag, "_rsp_write"}, {31'd0, rsp_write}, 32'd0);
    check({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
    check({tag, "_rsp_status"}, {30'd0, rsp_status}, 32'd0);
    check({tag, "_mmio_addr"}, mmio_addr, 32'd0);
    check({tag, "_mmio_wdata"}, mmio_wdata, 32'd0);
    check({tag, "_strobes"}, {30'd0, mmio_wr, mmio_rd}, 32'd0);
  endtask

  initial begin
    int w0, r0, t;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;
    #1;
    check("req_ready_after_reset", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1;

    // Write then read ID register
    w0 = wr_cnt; r0 = rd_cnt;
    issue(1'b1, 32'hBEEF_0004, 32'd5, 32'd0, ST_OK, 1);
    wait_rsp();
    issue(1'b0, 32'hBEEF_0008, 32'd0, 32'd47, ST_OK, 2);
    wait_rsp();
    check("one_wr_pulse", 32'(wr_cnt - w0), 32'd1);
    check("one_rd_pulse", 32'(rd_cnt - r0), 32'd1);

    // Scratch register and mirror
    issue(1'b1, 32'hBEEF_0000, 32'd3, 32'd0, ST_OK, 1);
    wait_rsp();
    issue(1'b0, 32'hBEEF_000C, 32'd0, 32'd3, ST_OK, 2);
    wait_rsp();
    issue(1'b0, 32'hBEEF_0000, 32'd0, 32'd3, ST_OK, 2);
    wait_rsp();
    issue(1'b0, 32'hBEEF_0010, 32'd0, 32'd0, ST_OK, 2);
    wait_rsp();

    // Faulted requests: no strobes, bus address retained
    w0 = wr_cnt; r0 = rd_cnt;
    issue(1'b0, 32'hBEEF_0002, 32'd0, 32'd0, ST_UNALIGNED, 0);
    wait_rsp();
    issue(1'b1, 32'hDEAD_0000, 32'd1, 32'd0, ST_WINDOW, 0);
    wait_rsp();
    issue(1'b1, 32'hDEAD_0001, 32'd1, 32'd0, ST_UNALIGNED, 0);
    wait_rsp();
    check("fault_no_wr", 32'(wr_cnt - w0), 32'd0);
    check("fault_no_rd", 32'(rd_cnt - r0), 32'd0);
    check("fault_addr_held", mmio_addr, 32'hBEEF_0010);
    check("fault_wdata_held", mmio_wdata, 32'd3);
    issue(1'b0, 32'hBEEF_0000, 32'd0, 32'd3, ST_OK, 2);
    wait_rsp();

    // Timeout with a silent downstream, then a stray read-valid in IDLE
    stub_mode = 1'b1;
    issue(1'b0, 32'hBEEF_0004, 32'd0, 32'd0, ST_TIMEOUT, 17);
    wait_rsp();
    stray = 1'b1;
    @(posedge clk);
    #1;
    stray = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stray_no_rsp", {31'd0, rsp_valid}, 32'd0);
    end
    check("stray_req_ready", {31'd0, req_ready}, 32'd1);
    stub_mode = 1'b0;
    @(posedge clk);
    #1;

    // Response back-pressure
    rsp_ready = 1'b0;
    issue(1'b0, 32'hBEEF_0008, 32'd0, 32'd47, ST_OK, 2);
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!rsp_valid && t < 20);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      check("hold_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check("hold_rsp_rdata", rsp_rdata, 32'd47);
      check("hold_rsp_status", {30'd0, rsp_status}, 32'd0);
      check("hold_req_ready", {31'd0, req_ready}, 32'd0);
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("resume_req_ready", {31'd0, req_ready}, 32'd1);
    check("resume_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    wait_rsp();

    // Reset while waiting for read data
    stub_mode = 1'b1;
    issue(1'b0, 32'hBEEF_0004, 32'd0, 32'd0, ST_OK, 2);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_all_zero("midreset");
    rst = 1'b0;
    exp_q.delete();
    stub_mode = 1'b0;
    #1;
    check("midreset_req_ready", {31'd0, req_ready}, 32'd1);
    issue(1'b1, 32'hBEEF_0000, 32'd9, 32'd0, ST_OK, 1);
    wait_rsp();
    issue(1'b0, 32'hBEEF_0000, 32'd0, 32'd9, ST_OK, 2);
    wait_rsp();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/mmio_host_bridge.md
Name: mmio_host_bridge

Overview:
- Upstream neighbour of the 4-byte-addressed MMIO register block.
- Accepts single register transactions from the simulated host/HAL driver over a valid/ready request channel.
- Converts each transaction into the MMIO block's single-cycle wr/rd strobe protocol and waits for read data.
- Returns a response with status over a valid/ready response channel, so software never drives raw strobes.

Parameters:
- WINDOW_HI, 16'hBEEF, required value of addr[31:16]; any other value is rejected without a bus access.
- TIMEOUT_CYCLES, 16, maximum cycles spent in RD_WAIT before a timeout response; must be ≥2.
- CNT_W, $clog2(TIMEOUT_CYCLES+1), width of the timeout counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active high (one clock; reset is synchronous and active-high).
- req_valid  in  1  host request valid.
- req_ready  out  1  bridge accepts a request this cycle.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  32  byte address.
- req_wdata  in  32  write data.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  host accepts the response.
- rsp_write  out  1  echo of req_write.
- rsp_rdata  out  32  read data; 0 for writes and errors.
- rsp_status  out  2  0 OK, 1 UNALIGNED, 2 OUT_OF_WINDOW, 3 TIMEOUT.
- mmio_addr  out  32  address to the MMIO block.
- mmio_wdata  out  32  write data to the MMIO block.
- mmio_wr  out  1  write strobe, one-cycle pulse.
- mmio_rd  out  1  read strobe, one-cycle pulse.
- mmio_rd_valid  in  1  read-valid from the MMIO block; arrives one cycle after mmio_rd.
- mmio_rdata  in  32  read data, valid with mmio_rd_valid.

Behaviour:
- Reset values: all outputs 0; state IDLE; counter 0. req_ready = (state==IDLE) && !rst.
- States:
  - IDLE: on req_valid && req_ready, capture the request.
    - addr[1:0] != 0 → RSP with UNALIGNED.
    - addr[31:16] != WINDOW_HI → RSP with OUT_OF_WINDOW.
    - Otherwise → WR_ISSUE if write, RD_ISSUE if read.
    - Alignment is checked first; if both faults apply, status is UNALIGNED.
    - Faulted requests never assert mmio_wr or mmio_rd.
  - WR_ISSUE: one cycle with mmio_wr=1 and mmio_addr/mmio_wdata = captured values → RSP with OK.
  - RD_ISSUE: one cycle with mmio_rd=1 and mmio_addr = captured address; clear counter → RD_WAIT.
  - RD_WAIT: mmio_addr held stable.
    - If mmio_rd_valid, capture mmio_rdata → RSP with OK.
    - Else increment counter; when counter reaches TIMEOUT_CYCLES → RSP with TIMEOUT and rdata 0.
  - RSP: rsp_valid=1. rsp_write, rsp_rdata and rsp_status stay stable until rsp_ready. On rsp_ready → IDLE (rsp_valid drops next cycle).
- mmio_addr and mmio_wdata are registered and retain their last value outside transactions. Strobes are 0 outside WR_ISSUE and RD_ISSUE.
- Latency from accept to rsp_valid:
  - write: 2 cycles.
  - read: 3 cycles with a standard MMIO block.
  - error: 1 cycle.
- Minimum spacing between accepts is 3 cycles for writes and 4 for reads. There is no overlap; one outstanding transaction at most.
- mmio_rd_valid outside RD_WAIT (late or stray) is ignored and does not corrupt a pending or future response.
- Reset in any state returns to IDLE next cycle. Strobes drop and any pending response is discarded without being presented.
- req_* inputs are don't-care unless req_valid && req_ready.

Decomposition:
- Package mmio_host_bridge_pkg holds:
  - state_t enum {IDLE, WR_ISSUE, RD_ISSUE, RD_WAIT, RSP};
  - status_t enum {ST_OK, ST_UNALIGNED, ST_WINDOW, ST_TIMEOUT} (2 bits);
  - the default WINDOW_HI constant.
- No sub-module: a single FSM with a captured-request register and a timeout counter.
- The bench instantiates the bridge with the real MMIO register block downstream, plus a stub that never returns rd_valid for the timeout test.

Test Plan:
- Write 0xBEEF0004 = 5, then read 0xBEEF0008 → write rsp OK; read rsp OK with rdata=47. Exactly one mmio_wr and one mmio_rd pulse each; read rsp_valid 3 cycles after accept.
- Write 0xBEEF0000 = 3, read 0xBEEF000C → rdata=3, OK. Read 0xBEEF0000 → 3. Read 0xBEEF0010 → rdata=0, OK.
- Read 0xBEEF0002 → UNALIGNED, rdata 0, no strobes. Write 0xDEAD0000 = 1 → OUT_OF_WINDOW, no mmio_wr; a following read of 0xBEEF0000 returns the prior value unchanged.
- Stub downstream never asserts rd_valid, TIMEOUT_CYCLES=16 → TIMEOUT response 17 cycles after RD_ISSUE. A stray rd_valid injected afterwards in IDLE → no rsp_valid.
- Hold rsp_ready low 5 cycles after a read of 47 → rsp_valid, rdata and status stable for all 5 cycles. req_ready stays 0 throughout; accept resumes the cycle after the handshake.
- Assert rst for 1 cycle while in RD_WAIT → next cycle all outputs 0 and state IDLE; no response emitted. A new write accepted 1 cycle after reset deasserts completes OK.
